// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux among four requesters, bounded bursts per grant.
// Optional per-requester grant counters are enabled by defining MUX_RR_ARBITER_STATS_EN.
module mux_rr_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req_i,
  input  logic [4*WIDTH-1:0] din_i,
  input  logic               out_ready_i,
  output logic [3:0]         gnt_o,
  output logic [1:0]         sel_o,
  output logic               out_valid_o,
  output logic [WIDTH-1:0]   out_data_o,
  output logic [3:0]         ack_o
`ifdef MUX_RR_ARBITER_STATS_EN
  ,
  output logic [4*8-1:0]     grant_cnt_o
`endif
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;

  logic       beat;
  logic       release_burst;
  logic [1:0] arb_start;
  logic [2:0] arb;

  // Returns {found, index}; the lowest offset from start wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign out_valid_o   = (state_q == StGrant) && req_i[sel_q];
  assign out_data_o    = out_valid_o ? din_i[sel_q*WIDTH +: WIDTH] : '0;
  assign beat          = out_valid_o && out_ready_i;
  assign ack_o         = beat ? gnt_q : 4'b0000;
  assign gnt_o         = gnt_q;
  assign sel_o         = sel_q;
  assign release_burst = (beat && (beat_cnt_q == 8'(BURST_MAX - 1))) || !req_i[sel_q];

  // On release the scan starts after the current owner, making it lowest priority.
  assign arb_start = (state_q == StGrant) ? sel_q + 2'd1 : ptr_q;
  assign arb       = rr_pick(req_i, arb_start);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (arb[2]) begin
          state_d    = StGrant;
          gnt_d      = 4'b0001 << arb[1:0];
          sel_d      = arb[1:0];
          beat_cnt_d = '0;
        end
      end
      StGrant: begin
        if (release_burst) begin
          ptr_d      = sel_q + 2'd1;
          beat_cnt_d = '0;
          if (arb[2]) begin
            gnt_d = 4'b0001 << arb[1:0];
            sel_d = arb[1:0];
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
            sel_d   = '0;
          end
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      sel_q      <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef MUX_RR_ARBITER_STATS_EN
  logic       new_grant;
  logic [7:0] grant_cnt_q [4];

  assign new_grant = arb[2] && ((state_q == StIdle) || release_burst);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) grant_cnt_q[i] <= '0;
    end else if (new_grant && (grant_cnt_q[arb[1:0]] != 8'hFF)) begin
      grant_cnt_q[arb[1:0]] <= grant_cnt_q[arb[1:0]] + 8'd1;
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int i = 0; i < 4; i++) grant_cnt_o[i*8 +: 8] = grant_cnt_q[i];
  end
`endif

endmodule
